// File: rtl/i2c_slave.sv
// I2C target: filtered SCL/SDA, START/STOP detection, masked 7-bit address match,
// write bytes out on a valid/ready stream, read bytes in from one, SCL stretching.
module i2c_slave #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       release_bus,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       busy,
  output logic [6:0] bus_address,
  output logic       bus_addressed,
  output logic       bus_active,
  input  logic       enable,
  input  logic [6:0] device_address,
  input  logic [6:0] device_address_mask
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE, ADDRESS, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK
  } state_t;

  state_t        state;
  logic [1:0]    scl_sync, sda_sync;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_d, sda_d;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          rw, ack_on, pend;

  logic scl_rise_c, scl_fall_c, start_c, stop_c, match_c;

  assign scl_t = scl_o;
  assign sda_t = sda_o;

  assign scl_rise_c = scl_f & ~scl_d;
  assign scl_fall_c = ~scl_f & scl_d;
  assign start_c    = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c     = scl_f & scl_d & ~sda_d & sda_f;
  assign match_c    = enable && (((shift[6:0] ^ device_address) & device_address_mask) == 7'd0);

  // Synchronizers and glitch filters; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end

  // Protocol FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      scl_o          <= 1'b1;
      sda_o          <= 1'b1;
      data_in_ready  <= 1'b0;
      data_out       <= 8'd0;
      data_out_valid <= 1'b0;
      busy           <= 1'b0;
      bus_address    <= 7'd0;
      bus_addressed  <= 1'b0;
      bus_active     <= 1'b0;
      shift          <= 8'd0;
      bit_cnt        <= 3'd0;
      rw             <= 1'b0;
      ack_on         <= 1'b0;
      pend           <= 1'b0;
    end else begin
      data_in_ready <= 1'b0;
      if (data_out_valid && data_out_ready) data_out_valid <= 1'b0;
      if (start_c)     bus_active <= 1'b1;
      else if (stop_c) bus_active <= 1'b0;

      if (release_bus || start_c || stop_c) begin
        state         <= (start_c && !release_bus) ? ADDRESS : IDLE;
        scl_o         <= 1'b1;
        sda_o         <= 1'b1;
        busy          <= 1'b0;
        bus_addressed <= 1'b0;
        bit_cnt       <= 3'd0;
        ack_on        <= 1'b0;
        pend          <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDRESS: if (scl_rise_c) begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (match_c) begin
                bus_address   <= shift[6:0];
                rw            <= sda_f;
                bus_addressed <= 1'b1;
                busy          <= 1'b1;
                ack_on        <= 1'b0;
                state         <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          ADDR_ACK: if (scl_fall_c) begin
            if (!ack_on) begin
              sda_o  <= 1'b0;
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= 3'd0;
              if (rw) begin
                pend  <= 1'b1;
                state <= READ_DATA;
              end else begin
                sda_o <= 1'b1;
                state <= WRITE_DATA;
              end
            end
          end
          WRITE_DATA: if (scl_rise_c) begin
            shift   <= {shift[6:0], sda_f};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_on <= 1'b0;
              state  <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            // ACK is set up while SCL is still held; SCL released a cycle later
            if (ack_on) begin
              scl_o <= 1'b1;
              if (scl_fall_c) begin
                sda_o   <= 1'b1;
                ack_on  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= WRITE_DATA;
              end
            end else if (pend || scl_fall_c) begin
              if (!data_out_valid) begin
                data_out       <= shift;
                data_out_valid <= 1'b1;
                sda_o          <= 1'b0;
                ack_on         <= 1'b1;
                pend           <= 1'b0;
              end else begin
                scl_o <= 1'b0;
                pend  <= 1'b1;
              end
            end
          end
          READ_DATA: begin
            if (pend) begin
              if (data_in_valid) begin
                shift         <= data_in;
                sda_o         <= data_in[7];
                data_in_ready <= 1'b1;
                pend          <= 1'b0;
                bit_cnt       <= 3'd0;
              end else begin
                scl_o <= 1'b0;
              end
            end else begin
              scl_o <= 1'b1;
              if (scl_fall_c) begin
                if (bit_cnt == 3'd7) begin
                  sda_o  <= 1'b1;
                  ack_on <= 1'b0;
                  state  <= READ_ACK;
                end else begin
                  shift   <= {shift[6:0], 1'b0};
                  sda_o   <= shift[6];
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
            end
          end
          READ_ACK: begin
            if (!ack_on) begin
              if (scl_rise_c) begin
                if (sda_f) begin
                  state         <= IDLE;
                  busy          <= 1'b0;
                  bus_addressed <= 1'b0;
                end else begin
                  ack_on <= 1'b1;
                end
              end
            end else if (scl_fall_c) begin
              ack_on <= 1'b0;
              pend   <= 1'b1;
              state  <= READ_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged open-drain master drives the bus and
// results are checked against hand-computed values.
module tb_i2c_slave;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       release_bus = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b1;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       busy, bus_addressed, bus_active;
  logic [6:0] bus_address;
  logic       enable = 1'b1;
  logic [6:0] device_address = 7'h50;
  logic [6:0] device_address_mask = 7'h7F;

  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic scl_bus, sda_bus;

  assign scl_bus = m_scl & (scl_t | scl_o);
  assign sda_bus = m_sda & (sda_t | sda_o);

  always #5 clk = ~clk;

  i2c_slave #(.FILTER_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .release_bus(release_bus),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
    .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .busy(busy), .bus_address(bus_address), .bus_addressed(bus_addressed),
    .bus_active(bus_active), .enable(enable),
    .device_address(device_address), .device_address_mask(device_address_mask)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] got[$];
  int         vcycles = 0;
  int         rdy_cnt = 0;
  int         sda_low_cnt = 0;

  // Bus-side monitor: completed write handshakes, valid cycles, read pops, SDA drive
  always @(posedge clk) begin
    if (data_out_valid && data_out_ready) got.push_back(data_out);
    if (data_out_valid) vcycles <= vcycles + 1;
    if (data_in_ready)  rdy_cnt <= rdy_cnt + 1;
    if (!sda_t)         sda_low_cnt <= sda_low_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    m_scl = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3000 && !scl_bus; i++) @(negedge clk);
    if (!scl_bus) begin
      errors++;
      $error("FAIL scl_release: observed=0 expected=1");
    end
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b;
    cyc(Q);
    scl_high();
    cyc(Q);
    r = sda_bus;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic m_start();
    m_sda = 1'b0;
    cyc(2 * Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic m_rstart();
    m_sda = 1'b1;
    cyc(Q);
    scl_high();
    cyc(Q);
    m_sda = 1'b0;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0;
    cyc(Q);
    scl_high();
    cyc(Q);
    m_sda = 1'b1;
    cyc(2 * Q);
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_read(output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         base_q, base_v, base_low;

    // Reset values
    cyc(3);
    chk("reset_ctl", 32'({scl_o, scl_t, sda_o, sda_t, data_in_ready, data_out_valid,
                          busy, bus_addressed, bus_active}), 32'h1E0);
    chk("reset_data", 32'({data_out, 1'b0, bus_address}), 32'h0);
    rst_n = 1'b1;
    cyc(5);

    // Addressed write of two bytes
    base_q = got.size();
    base_v = vcycles;
    m_start();
    cyc(2);
    chk("start_active", 32'(bus_active), 32'h1);
    m_write(8'hA0, ack);
    chk("wr_addr_ack", 32'(ack), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);
    chk("wr_bus_address", 32'(bus_address), 32'h50);
    m_write(8'h11, ack);
    chk("wr_b0_ack", 32'(ack), 32'h0);
    m_write(8'h22, ack);
    chk("wr_b1_ack", 32'(ack), 32'h0);
    m_stop();
    chk("wr_busy_after_stop", 32'(busy), 32'h0);
    chk("wr_active_after_stop", 32'(bus_active), 32'h0);
    chk("wr_count", 32'(got.size() - base_q), 32'd2);
    if (got.size() >= base_q + 2) begin
      chk("wr_data0", 32'(got[base_q]), 32'h11);
      chk("wr_data1", 32'(got[base_q + 1]), 32'h22);
    end
    chk("wr_valid_cycles", 32'(vcycles - base_v), 32'd2);

    // Read two bytes, ACK then NACK
    base_v = rdy_cnt;
    data_in = 8'hAB;
    data_in_valid = 1'b1;
    m_start();
    m_write(8'hA1, ack);
    chk("rd_addr_ack", 32'(ack), 32'h0);
    m_read(d);
    chk("rd_byte0", 32'(d), 32'hAB);
    data_in = 8'hCD;
    m_bit(1'b0, r);
    m_read(d);
    chk("rd_byte1", 32'(d), 32'hCD);
    m_bit(1'b1, r);
    cyc(Q);
    chk("rd_busy_after_nack", 32'(busy), 32'h0);
    chk("rd_sda_released", 32'(sda_t), 32'h1);
    chk("rd_ready_pulses", 32'(rdy_cnt - base_v), 32'd2);
    data_in_valid = 1'b0;
    m_stop();

    // Address mismatch
    base_q = got.size();
    base_low = sda_low_cnt;
    m_start();
    m_write(8'hA2, ack);
    chk("mis_nack", 32'(ack), 32'h1);
    chk("mis_addressed", 32'(bus_addressed), 32'h0);
    chk("mis_active", 32'(bus_active), 32'h1);
    m_write(8'h55, ack);
    chk("mis_sda_never_low", 32'(sda_low_cnt - base_low), 32'd0);
    chk("mis_no_data", 32'(got.size() - base_q), 32'd0);
    m_stop();
    chk("mis_active_stop", 32'(bus_active), 32'h0);

    // Clock stretching on an unconsumed byte
    base_q = got.size();
    m_start();
    m_write(8'hA0, ack);
    data_out_ready = 1'b0;
    m_write(8'h11, ack);
    chk("st_b0_ack", 32'(ack), 32'h0);
    chk("st_b0_valid", 32'(data_out_valid), 32'h1);
    fork
      m_write(8'h22, ack);
      begin
        for (int i = 0; i < 2000 && scl_o; i++) cyc(1);
        cyc(200);
        chk("st_scl_held", 32'(scl_o), 32'h0);
        chk("st_old_data", 32'(data_out), 32'h11);
        data_out_ready = 1'b1;
      end
    join
    chk("st_b1_ack", 32'(ack), 32'h0);
    chk("st_b1_data", 32'(data_out), 32'h22);
    m_stop();
    chk("st_count", 32'(got.size() - base_q), 32'd2);
    if (got.size() >= base_q + 2) chk("st_order", 32'({got[base_q], got[base_q + 1]}), 32'h1122);

    // Repeated START into a read
    m_start();
    m_write(8'hA0, ack);
    m_write(8'h01, ack);
    chk("rs_wr_ack", 32'(ack), 32'h0);
    data_in = 8'h5A;
    data_in_valid = 1'b1;
    m_rstart();
    m_write(8'hA1, ack);
    chk("rs_addr_ack", 32'(ack), 32'h0);
    chk("rs_busy", 32'(busy), 32'h1);
    chk("rs_addressed", 32'(bus_addressed), 32'h1);
    m_read(d);
    chk("rs_byte", 32'(d), 32'h5A);
    m_bit(1'b1, r);
    data_in_valid = 1'b0;
    m_stop();
    chk("rs_last_write", 32'(got[got.size() - 1]), 32'h01);

    // Asynchronous reset while ACK is driven
    m_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'hA0;
      m_bit(d[i], r);
    end
    m_sda = 1'b1;
    for (int i = 0; i < 100 && sda_t; i++) cyc(1);
    chk("ar_ack_driven", 32'(sda_t), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("ar_sda_released", 32'(sda_t), 32'h1);
    chk("ar_scl_released", 32'(scl_t), 32'h1);
    cyc(2);
    rst_n = 1'b1;
    m_scl = 1'b1;
    cyc(4 * Q);

    // release_bus during a stretch keeps the pending byte
    data_out_ready = 1'b0;
    m_start();
    m_write(8'hA0, ack);
    m_write(8'h33, ack);
    chk("rb_b0_ack", 32'(ack), 32'h0);
    fork
      m_write(8'h44, ack);
      begin
        for (int i = 0; i < 2000 && scl_o; i++) cyc(1);
        cyc(20);
        chk("rb_stretching", 32'(scl_t), 32'h0);
        release_bus = 1'b1;
        cyc(1);
        release_bus = 1'b0;
        chk("rb_scl_released", 32'(scl_t), 32'h1);
        chk("rb_sda_released", 32'(sda_t), 32'h1);
        chk("rb_valid_kept", 32'(data_out_valid), 32'h1);
        chk("rb_data_kept", 32'(data_out), 32'h33);
      end
    join
    chk("rb_nack", 32'(ack), 32'h1);
    m_stop();
    data_out_ready = 1'b1;
    cyc(3);
    chk("rb_drained", 32'(got[got.size() - 1]), 32'h33);
    chk("rb_valid_clear", 32'(data_out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
